pipe_stage_reg: RTL and testbench

- Parametrised pipeline boundary register between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Successor to the fixed-field hold-or-load stage registers.
- Carries one packed payload bus under a valid/ready handshake, with optional 2-entry skid buffering so in_ready is fully registered.
- Supports a same-cycle flush for exceptions and branch squashing, plus a saturating back-pressure cycle counter for performance statistics.

---
 rtl/pipe_stage_reg_pkg.sv | 24 ++
 rtl/pipe_stage_reg_sat_counter.sv | 32 +++
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_reg.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and helpers for pipeline boundary registers.
// The state encoding doubles as the occupancy count.
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    // Increment cnt, holding at the largest value representable in w bits (w <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 32'd64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        if (cnt >= max_v) begin
            return cnt;
        end else begin
            return cnt + 64'd1;
        end
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous reset and clear.
// Clear has priority over increment; usable for any performance statistic.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_r;

    // Counter state: reset, clear, saturating increment, or hold.
    always_ff @(posedge clk) begin
        if (rset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            cnt_r <= CNT_W'(sat_inc(64'(cnt_r), CNT_W));
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, optional 2-entry skid,
// same-cycle flush and a saturating back-pressure counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                SKID      = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    pipe_state_e       state_r;
    logic [DATA_W-1:0] main_r;
    logic [DATA_W-1:0] skid_r;
    logic              in_ready_r;
    logic              in_fire_s;
    logic              out_fire_s;
    logic              stall_s;

    assign out_valid  = (state_r != EMPTY);
    assign occupancy  = state_r;
    assign out_data   = main_r;
    // Without a skid entry, a full stage can only accept when the head leaves.
    assign in_ready   = (SKID != 0) ? in_ready_r : (out_ready | ~out_valid);
    assign in_fire_s  = in_valid & in_ready & ~flush;
    assign out_fire_s = out_valid & out_ready;
    assign stall_s    = out_valid & ~out_ready;

    // Handshake FSM and payload registers; in_ready_r tracks (next state != TWO).
    always_ff @(posedge clk) begin
        if (rset) begin
            state_r    <= EMPTY;
            main_r     <= RESET_VAL;
            skid_r     <= RESET_VAL;
            in_ready_r <= 1'b1;
        end else if (flush) begin
            state_r    <= EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        main_r  <= in_data;
                        state_r <= ONE;
                    end else begin
                        state_r <= EMPTY;
                    end
                    in_ready_r <= 1'b1;
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_r     <= in_data;
                        state_r    <= ONE;
                        in_ready_r <= 1'b1;
                    end else if (in_fire_s && (SKID != 0)) begin
                        skid_r     <= in_data;
                        state_r    <= TWO;
                        in_ready_r <= 1'b0;
                    end else if (in_fire_s) begin
                        main_r     <= in_data;
                        state_r    <= ONE;
                        in_ready_r <= 1'b1;
                    end else if (out_fire_s) begin
                        state_r    <= EMPTY;
                        in_ready_r <= 1'b1;
                    end else begin
                        state_r    <= ONE;
                        in_ready_r <= 1'b1;
                    end
                end
                TWO: begin
                    if (out_fire_s) begin
                        main_r     <= skid_r;
                        state_r    <= ONE;
                        in_ready_r <= 1'b1;
                    end else begin
                        state_r    <= TWO;
                        in_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= EMPTY;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rset (rset),
        .inc  (stall_s),
        .clr  (stall_clr),
        .cnt  (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 instance checked against a payload
// scoreboard plus direct checks, and a SKID=0 instance for the push/pop case.
module tb_pipe_stage_reg;

    logic       clk = 1'b0;
    logic       rset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] occupancy;
    logic [3:0] stall_cnt;
    logic       stall_clr;

    logic       in_valid0;
    logic       in_ready0;
    logic [7:0] in_data0;
    logic       out_valid0;
    logic       out_ready0;
    logic [7:0] out_data0;
    logic [1:0] occupancy0;
    logic [3:0] stall_cnt0;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(8), .SKID(1), .RESET_VAL(8'h5A), .CNT_W(4)
    ) dut1 (
        .clk(clk), .rset(rset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );

    pipe_stage_reg #(
        .DATA_W(8), .SKID(0), .RESET_VAL(8'h5A), .CNT_W(4)
    ) dut0 (
        .clk(clk), .rset(rset), .flush(1'b0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .occupancy(occupancy0), .stall_cnt(stall_cnt0), .stall_clr(1'b0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: record accepted payloads and compare each delivered one in order.
    always @(negedge clk) begin
        if (rset) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected", 64'(out_data), 64'hFFFF);
                end else begin
                    check("sb_data", 64'(out_data), 64'(sb_q[0]));
                    void'(sb_q.pop_front());
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
            end
        end
    end

    initial begin
        rset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b1; stall_clr = 1'b0;
        in_valid0 = 1'b0; in_data0 = 8'h00; out_ready0 = 1'b1;

        // Reset, then pass-through with out_ready held high
        tick(); tick();
        rset = 1'b0;
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_data", 64'(out_data), 64'h5A);
        check("rst0_occ", 64'(occupancy0), 64'd0);
        in_valid = 1'b1; in_data = 8'h11; tick();
        check("pt_d11", 64'(out_data), 64'h11);
        check("pt_rdy1", 64'(in_ready), 64'd1);
        in_data = 8'h22; tick();
        check("pt_d22", 64'(out_data), 64'h22);
        check("pt_rdy2", 64'(in_ready), 64'd1);
        in_data = 8'h33; tick();
        check("pt_d33", 64'(out_data), 64'h33);
        in_valid = 1'b0; tick();
        check("pt_empty", 64'(out_valid), 64'd0);
        check("pt_stall", 64'(stall_cnt), 64'd0);

        // Back-pressure fill into the skid entry, then drain in order
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA0; tick();
        check("bp_occ1", 64'(occupancy), 64'd1);
        check("bp_rdy1", 64'(in_ready), 64'd1);
        in_data = 8'hA1; tick();
        check("bp_occ2", 64'(occupancy), 64'd2);
        check("bp_rdy2", 64'(in_ready), 64'd0);
        check("bp_head", 64'(out_data), 64'hA0);
        in_valid = 1'b0; tick();
        check("bp_hold", 64'(out_data), 64'hA0);
        check("bp_stall", 64'(stall_cnt), 64'd2);
        out_ready = 1'b1; tick();
        check("bp_pop1", 64'(out_data), 64'hA1);
        check("bp_rdy3", 64'(in_ready), 64'd1);
        check("bp_occ3", 64'(occupancy), 64'd1);
        tick();
        check("bp_occ0", 64'(occupancy), 64'd0);

        // Flush while full with an input offered
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hB0; tick();
        in_data = 8'hB1; tick();
        check("fl_occ2", 64'(occupancy), 64'd2);
        in_data = 8'hFF; flush = 1'b1; tick();
        flush = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_occ", 64'(occupancy), 64'd0);
        check("fl_rdy", 64'(in_ready), 64'd1);
        check("fl_stall", 64'(stall_cnt), 64'd4);
        out_ready = 1'b1; in_data = 8'hC0; tick();
        check("fl_next", 64'(out_data), 64'hC0);
        in_valid = 1'b0; tick();

        // Simultaneous push/pop in ONE on both variants
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h05;
        out_ready0 = 1'b0; in_valid0 = 1'b1; in_data0 = 8'h05; tick();
        check("pp_d5", 64'(out_data), 64'h05);
        check("pp0_d5", 64'(out_data0), 64'h05);
        check("pp0_rdy", 64'(in_ready0), 64'd0);
        out_ready = 1'b1; in_data = 8'h06;
        out_ready0 = 1'b1; in_data0 = 8'h06; tick();
        check("pp_d6", 64'(out_data), 64'h06);
        check("pp_occ", 64'(occupancy), 64'd1);
        check("pp0_d6", 64'(out_data0), 64'h06);
        check("pp0_occ", 64'(occupancy0), 64'd1);
        in_valid = 1'b0; in_valid0 = 1'b0; tick();
        check("pp_empty", 64'(occupancy), 64'd0);
        check("pp0_empty", 64'(occupancy0), 64'd0);
        check("pp0_stall", 64'(stall_cnt0), 64'd0);

        // Counter saturation and clear priority
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hD0; tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check("sat_max", 64'(stall_cnt), 64'd15);
        stall_clr = 1'b1; tick();
        check("sat_clr", 64'(stall_cnt), 64'd0);
        stall_clr = 1'b0; tick();
        check("sat_resume", 64'(stall_cnt), 64'd1);
        check("sat_hold", 64'(out_data), 64'hD0);
        out_ready = 1'b1; tick();
        check("sat_drain", 64'(occupancy), 64'd0);

        // Reset while full, alongside input and flush
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hE0; tick();
        in_data = 8'hE1; tick();
        check("mr_occ2", 64'(occupancy), 64'd2);
        in_data = 8'hE2; flush = 1'b1; rset = 1'b1; tick();
        rset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        check("mr_occ", 64'(occupancy), 64'd0);
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_data", 64'(out_data), 64'h5A);
        check("mr_stall", 64'(stall_cnt), 64'd0);
        check("mr_rdy", 64'(in_ready), 64'd1);
        tick(); tick();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
